// File: rtl/gpu_ram_arbiter.sv
// Shares the single GPU RAM port between the Z80 bus (A), the RS232 debugger (B) and the
// geometry unit (C). A/B alternate; C takes spare cycles or is forced in by a starvation watchdog.
module gpu_ram_arbiter #(
  parameter int unsigned READ_CLOCK_CYCLES = 2,
  parameter int unsigned GEO_MAX_WAIT      = 8,
  parameter bit          GEO_ENDIAN_SWAP   = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        a_req,
  input  logic        b_req,
  input  logic        c_req,
  input  logic        a_wr,
  input  logic        b_wr,
  input  logic        c_wr,
  input  logic [19:0] a_addr,
  input  logic [19:0] b_addr,
  input  logic [19:0] c_addr,
  input  logic [7:0]  a_wdata,
  input  logic [7:0]  b_wdata,
  input  logic [15:0] c_wdata,
  output logic        a_ack,
  output logic        b_ack,
  output logic        c_ack,
  output logic        ram_rd_req,
  output logic        ram_wr_ena,
  output logic        ram_ena_16bit,
  output logic [19:0] ram_address,
  output logic [15:0] ram_data_out,
  input  logic [15:0] ram_data_in,
  output logic        a_rd_rdy,
  output logic        b_rd_rdy,
  output logic        c_rd_rdy,
  output logic [15:0] rd_data,
  output logic        geo_forced
);

  localparam int unsigned AW = 20;
  localparam int unsigned DW = 16;
  localparam int unsigned BW = 8;
  localparam int unsigned WW = 8;

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_A    = 2'd1,
    TAG_B    = 2'd2,
    TAG_C    = 2'd3
  } tag_e;

  typedef struct packed {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } acc_t;

  function automatic logic [DW-1:0] byte_swap(input logic [DW-1:0] v);
    return {v[BW-1:0], v[DW-1:BW]};
  endfunction

  logic [WW-1:0] wait_cnt;
  logic          last_b;
  logic          force_c;
  tag_e          grant;
  acc_t          sel;
  logic [DW-1:0] c_wdata_ram;
  tag_e          tag_q [READ_CLOCK_CYCLES+1];
  tag_e          tag_out;

  assign c_wdata_ram = GEO_ENDIAN_SWAP ? byte_swap(c_wdata) : c_wdata;

  // Grant priority: watchdog-forced C, A/B tie by round-robin, lone A/B, then spare-cycle C.
  always_comb begin
    grant   = TAG_NONE;
    force_c = 1'b0;
    if (reset) begin
      if (c_req && (wait_cnt == WW'(GEO_MAX_WAIT))) begin
        grant   = TAG_C;
        force_c = 1'b1;
      end else if (a_req && b_req) begin
        grant = last_b ? TAG_A : TAG_B;
      end else if (a_req) begin
        grant = TAG_A;
      end else if (b_req) begin
        grant = TAG_B;
      end else if (c_req) begin
        grant = TAG_C;
      end
    end
  end

  assign a_ack = (grant == TAG_A);
  assign b_ack = (grant == TAG_B);
  assign c_ack = (grant == TAG_C);

  always_comb begin
    sel = '0;
    case (grant)
      TAG_A: begin
        sel.wr    = a_wr;
        sel.addr  = a_addr;
        sel.wdata = {{(DW-BW){1'b0}}, a_wdata};
      end
      TAG_B: begin
        sel.wr    = b_wr;
        sel.addr  = b_addr;
        sel.wdata = {{(DW-BW){1'b0}}, b_wdata};
      end
      TAG_C: begin
        sel.wr    = c_wr;
        sel.addr  = c_addr;
        sel.wdata = c_wdata_ram;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ram_rd_req    <= 1'b0;
      ram_wr_ena    <= 1'b0;
      ram_ena_16bit <= 1'b0;
      ram_address   <= '0;
      ram_data_out  <= '0;
      geo_forced    <= 1'b0;
      wait_cnt      <= '0;
      last_b        <= 1'b1;
      for (int unsigned i = 0; i <= READ_CLOCK_CYCLES; i++) tag_q[i] <= TAG_NONE;
    end else begin
      geo_forced <= force_c;

      // Idle cycles drop the strobes but keep address/data stable on the RAM bus.
      if (grant != TAG_NONE) begin
        ram_address   <= sel.addr;
        ram_data_out  <= sel.wdata;
        ram_wr_ena    <= sel.wr;
        ram_rd_req    <= !sel.wr;
        ram_ena_16bit <= (grant == TAG_C);
      end else begin
        ram_wr_ena    <= 1'b0;
        ram_rd_req    <= 1'b0;
        ram_ena_16bit <= 1'b0;
      end

      if (grant == TAG_A) last_b <= 1'b0;
      else if (grant == TAG_B) last_b <= 1'b1;

      if (!c_req || (grant == TAG_C)) wait_cnt <= '0;
      else if (wait_cnt != WW'(GEO_MAX_WAIT)) wait_cnt <= wait_cnt + WW'(1);

      tag_q[0] <= ((grant != TAG_NONE) && !sel.wr) ? grant : TAG_NONE;
      for (int unsigned i = 1; i <= READ_CLOCK_CYCLES; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  // The tag leaving the pipeline lines up with the RAM read data for that request.
  assign tag_out  = tag_q[READ_CLOCK_CYCLES];
  assign a_rd_rdy = (tag_out == TAG_A);
  assign b_rd_rdy = (tag_out == TAG_B);
  assign c_rd_rdy = (tag_out == TAG_C);
  assign rd_data  = (GEO_ENDIAN_SWAP && (tag_out == TAG_C)) ? byte_swap(ram_data_in) : ram_data_in;

endmodule

// File: tb/tb_gpu_ram_arbiter.sv
// Bench for gpu_ram_arbiter: grant table, directed corner sequences and random traffic,
// all cross-checked every cycle against a transaction-level reference model.
module tb_gpu_ram_arbiter;

  localparam int RCC  = 2;
  localparam int MAXW = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        a_req, b_req, c_req, a_wr, b_wr, c_wr;
  logic [19:0] a_addr, b_addr, c_addr;
  logic [7:0]  a_wdata, b_wdata;
  logic [15:0] c_wdata;
  logic        a_ack, b_ack, c_ack;
  logic        ram_rd_req, ram_wr_ena, ram_ena_16bit;
  logic [19:0] ram_address;
  logic [15:0] ram_data_out, ram_data_in;
  logic        a_rd_rdy, b_rd_rdy, c_rd_rdy;
  logic [15:0] rd_data;
  logic        geo_forced;

  always #5 clk = ~clk;

  gpu_ram_arbiter #(
    .READ_CLOCK_CYCLES(RCC),
    .GEO_MAX_WAIT     (MAXW),
    .GEO_ENDIAN_SWAP  (1'b1)
  ) dut (
    .clk(clk), .reset(reset),
    .a_req(a_req), .b_req(b_req), .c_req(c_req),
    .a_wr(a_wr), .b_wr(b_wr), .c_wr(c_wr),
    .a_addr(a_addr), .b_addr(b_addr), .c_addr(c_addr),
    .a_wdata(a_wdata), .b_wdata(b_wdata), .c_wdata(c_wdata),
    .a_ack(a_ack), .b_ack(b_ack), .c_ack(c_ack),
    .ram_rd_req(ram_rd_req), .ram_wr_ena(ram_wr_ena), .ram_ena_16bit(ram_ena_16bit),
    .ram_address(ram_address), .ram_data_out(ram_data_out), .ram_data_in(ram_data_in),
    .a_rd_rdy(a_rd_rdy), .b_rd_rdy(b_rd_rdy), .c_rd_rdy(c_rd_rdy),
    .rd_data(rd_data), .geo_forced(geo_forced)
  );

  typedef struct {
    int         due;
    logic [1:0] port;
  } ret_t;

  typedef struct {
    logic [2:0] req;
    logic [2:0] ack;
    logic       geo;
  } vec_t;

  typedef struct {
    bit          act;
    bit          wr;
    logic [19:0] addr;
    logic [15:0] wd;
  } rq_t;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc   = 0;
  bit          m_last_a;
  int          m_cwait;
  logic        m_rd, m_wr, m_e16, m_geo;
  logic [19:0] m_addr;
  logic [15:0] m_data;
  ret_t        rq[$];
  logic [2:0]  m_grant, obs_ack, obs_rdy;
  logic [15:0] obs_rdata;
  logic        obs_geo;
  vec_t        tbl[15];
  rq_t         pr[3];

  function automatic logic [15:0] bswap(input logic [15:0] v);
    return {v[7:0], v[15:8]};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_clear();
    m_last_a = 1'b0;
    m_cwait  = 0;
    {m_rd, m_wr, m_e16, m_geo} = '0;
    m_addr = '0;
    m_data = '0;
    rq.delete();
  endtask

  // One clock: sample combinational/registered outputs, compare with the model, advance the model.
  task automatic cycle(input logic [15:0] rdata);
    logic [2:0]  eg, erdy;
    logic        forced, gw;
    logic [19:0] ga;
    logic [15:0] gd, edata;
    logic [1:0]  port;
    ram_data_in = rdata;
    #1;
    eg = 3'b000;
    forced = 1'b0;
    if (reset) begin
      if (c_req && m_cwait >= MAXW) begin eg = 3'b001; forced = 1'b1; end
      else if (a_req && b_req) eg = m_last_a ? 3'b010 : 3'b100;
      else if (a_req) eg = 3'b100;
      else if (b_req) eg = 3'b010;
      else if (c_req) eg = 3'b001;
    end
    m_grant   = eg;
    obs_ack   = {a_ack, b_ack, c_ack};
    obs_rdy   = {a_rd_rdy, b_rd_rdy, c_rd_rdy};
    obs_rdata = rd_data;
    obs_geo   = geo_forced;
    chk("ack", 64'(obs_ack), 64'(eg));
    chk("ram_bus", 64'({ram_rd_req, ram_wr_ena, ram_ena_16bit, ram_address, ram_data_out}),
        64'({m_rd, m_wr, m_e16, m_addr, m_data}));
    chk("geo_forced", 64'(obs_geo), 64'(m_geo));
    erdy  = 3'b000;
    edata = rdata;
    if (rq.size() > 0 && rq[0].due == cyc) begin
      case (rq[0].port)
        2'd1: erdy = 3'b100;
        2'd2: erdy = 3'b010;
        default: begin erdy = 3'b001; edata = bswap(rdata); end
      endcase
      void'(rq.pop_front());
    end
    chk("rd_rdy", 64'(obs_rdy), 64'(erdy));
    if (erdy != 3'b000) chk("rd_data", 64'(obs_rdata), 64'(edata));

    if (!reset) begin
      model_clear();
    end else begin
      m_geo = forced;
      if (eg != 3'b000) begin
        if (eg == 3'b100) begin ga = a_addr; gw = a_wr; gd = {8'h00, a_wdata}; port = 2'd1; end
        else if (eg == 3'b010) begin ga = b_addr; gw = b_wr; gd = {8'h00, b_wdata}; port = 2'd2; end
        else begin ga = c_addr; gw = c_wr; gd = bswap(c_wdata); port = 2'd3; end
        m_rd = !gw; m_wr = gw; m_e16 = (eg == 3'b001); m_addr = ga; m_data = gd;
        if (!gw) rq.push_back('{cyc + 1 + RCC, port});
      end else begin
        {m_rd, m_wr, m_e16} = '0;
      end
      if (eg == 3'b100) m_last_a = 1'b1;
      if (eg == 3'b010) m_last_a = 1'b0;
      if (c_req && eg != 3'b001) m_cwait = (m_cwait < MAXW) ? m_cwait + 1 : m_cwait;
      else m_cwait = 0;
    end
    cyc++;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_req(input logic a, input logic b, input logic c);
    a_req = a; b_req = b; c_req = c;
  endtask

  task automatic idle(input int n);
    set_req(0, 0, 0);
    for (int i = 0; i < n; i++) cycle(16'($urandom));
  endtask

  initial begin
    tbl[0]  = '{3'b000, 3'b000, 1'b0};
    tbl[1]  = '{3'b001, 3'b001, 1'b0};
    tbl[2]  = '{3'b110, 3'b100, 1'b0};
    tbl[3]  = '{3'b110, 3'b010, 1'b0};
    tbl[4]  = '{3'b100, 3'b100, 1'b0};
    tbl[5]  = '{3'b110, 3'b010, 1'b0};
    tbl[6]  = '{3'b010, 3'b010, 1'b0};
    tbl[7]  = '{3'b110, 3'b100, 1'b0};
    tbl[8]  = '{3'b011, 3'b010, 1'b0};
    tbl[9]  = '{3'b011, 3'b010, 1'b0};
    tbl[10] = '{3'b011, 3'b010, 1'b0};
    tbl[11] = '{3'b011, 3'b010, 1'b0};
    tbl[12] = '{3'b011, 3'b001, 1'b0};
    tbl[13] = '{3'b101, 3'b100, 1'b1};
    tbl[14] = '{3'b001, 3'b001, 1'b0};

    reset = 1'b0;
    set_req(1, 1, 1);
    {a_wr, b_wr, c_wr} = 3'b000;
    a_addr = 20'h0000A; b_addr = 20'h0000B; c_addr = 20'h0000C;
    a_wdata = 8'h11; b_wdata = 8'h22; c_wdata = 16'h3344;
    ram_data_in = '0;
    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);

    // Reset held with every requester active: no grants, outputs idle, A wins on release.
    for (int i = 0; i < 3; i++) begin
      cycle(16'($urandom));
      chk("reset_no_ack", 64'(obs_ack), 64'(3'b000));
    end
    chk("reset_outputs", 64'({ram_rd_req, ram_wr_ena, ram_ena_16bit, ram_address, ram_data_out,
                              geo_forced, a_rd_rdy, b_rd_rdy, c_rd_rdy}), 64'(0));
    reset = 1'b1;
    cycle(16'($urandom));
    chk("first_ack_after_reset", 64'(obs_ack), 64'(3'b100));
    idle(4);

    // Grant table from a fresh reset.
    reset = 1'b0;
    idle(1);
    reset = 1'b1;
    for (int i = 0; i < 15; i++) begin
      set_req(tbl[i].req[2], tbl[i].req[1], tbl[i].req[0]);
      cycle(16'($urandom));
      chk($sformatf("vec%0d_ack", i), 64'(obs_ack), 64'(tbl[i].ack));
      chk($sformatf("vec%0d_geo", i), 64'(obs_geo), 64'(tbl[i].geo));
    end
    idle(4);

    // Lone A read: request at n, RAM strobe at n+1, ready with data at n+3.
    a_wr = 1'b0; a_addr = 20'h12345;
    set_req(1, 0, 0);
    cycle(16'($urandom));
    chk("a_read_ack", 64'(obs_ack), 64'(3'b100));
    set_req(0, 0, 0);
    chk("a_read_ram", 64'({ram_rd_req, ram_wr_ena, ram_address}), 64'({1'b1, 1'b0, 20'h12345}));
    cycle(16'($urandom));
    cycle(16'($urandom));
    cycle(16'hBEEF);
    chk("a_read_rdy", 64'(obs_rdy), 64'(3'b100));
    chk("a_read_data", 64'(obs_rdata[7:0]), 64'(8'hEF));
    idle(2);

    // B write leaves B as last winner, so a sustained A/B tie starts with A.
    b_wr = 1'b1; b_addr = 20'h00BBB; b_wdata = 8'h5A;
    set_req(0, 1, 0);
    cycle(16'($urandom));
    chk("b_write_ack", 64'(obs_ack), 64'(3'b010));
    b_wr = 1'b0;
    set_req(1, 1, 0);
    for (int i = 0; i < 6; i++) begin
      cycle(16'($urandom));
      chk($sformatf("ab_alt%0d", i), 64'(obs_ack), 64'((i % 2 == 0) ? 3'b100 : 3'b010));
    end
    idle(4);

    // Watchdog: A, B, C all from cycle 0; C forced on cycle 4, geo_forced on cycle 5.
    c_wr = 1'b0;
    set_req(1, 1, 1);
    for (int i = 0; i < 8; i++) begin
      logic [2:0] ew;
      ew = (i == 4) ? 3'b001 : ((i < 4 ? i : i - 1) % 2 == 0) ? 3'b100 : 3'b010;
      cycle(16'($urandom));
      chk($sformatf("wd_ack%0d", i), 64'(obs_ack), 64'(ew));
      chk($sformatf("wd_geo%0d", i), 64'(obs_geo), 64'(i == 5));
      if (obs_ack[0]) c_req = 1'b0;
    end
    idle(4);

    // C write is byte-swapped onto the 16-bit bus; C read data is swapped back.
    c_wr = 1'b1; c_addr = 20'h00100; c_wdata = 16'h1234;
    set_req(0, 0, 1);
    cycle(16'($urandom));
    chk("c_write_ack", 64'(obs_ack), 64'(3'b001));
    set_req(0, 0, 0);
    chk("c_write_ram", 64'({ram_wr_ena, ram_rd_req, ram_ena_16bit, ram_address, ram_data_out}),
        64'({1'b1, 1'b0, 1'b1, 20'h00100, 16'h3412}));
    c_wr = 1'b0;
    set_req(0, 0, 1);
    cycle(16'($urandom));
    set_req(0, 0, 0);
    cycle(16'($urandom));
    cycle(16'($urandom));
    cycle(16'hAABB);
    chk("c_read_rdy", 64'(obs_rdy), 64'(3'b001));
    chk("c_read_data", 64'(obs_rdata), 64'(16'hBBAA));
    idle(3);

    // Reset while a B read is in flight: the read never returns; a later read does.
    b_wr = 1'b0; b_addr = 20'h54321;
    set_req(0, 1, 0);
    cycle(16'($urandom));
    chk("b_flight_ack", 64'(obs_ack), 64'(3'b010));
    set_req(0, 0, 0);
    reset = 1'b0;
    cycle(16'($urandom));
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle(16'($urandom));
      chk("b_flight_no_rdy", 64'(obs_rdy[1]), 64'(0));
    end
    set_req(0, 1, 0);
    cycle(16'($urandom));
    set_req(0, 0, 0);
    cycle(16'($urandom));
    cycle(16'($urandom));
    cycle(16'h00C3);
    chk("b_after_reset_rdy", 64'(obs_rdy), 64'(3'b010));
    chk("b_after_reset_data", 64'(obs_rdata[7:0]), 64'(8'hC3));
    idle(3);

    // Random traffic with requests held until acked and occasional resets.
    for (int p = 0; p < 3; p++) pr[p].act = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      for (int p = 0; p < 3; p++) begin
        if (!pr[p].act && $urandom_range(0, 3) == 0) begin
          pr[p].act  = 1'b1;
          pr[p].wr   = 1'($urandom_range(0, 1));
          pr[p].addr = 20'($urandom);
          pr[p].wd   = 16'($urandom);
        end
      end
      reset = ($urandom_range(0, 299) != 0);
      a_req = pr[0].act; a_wr = pr[0].wr; a_addr = pr[0].addr; a_wdata = pr[0].wd[7:0];
      b_req = pr[1].act; b_wr = pr[1].wr; b_addr = pr[1].addr; b_wdata = pr[1].wd[7:0];
      c_req = pr[2].act; c_wr = pr[2].wr; c_addr = pr[2].addr; c_wdata = pr[2].wd;
      cycle(16'($urandom));
      for (int p = 0; p < 3; p++) begin
        if (m_grant[2-p]) begin
          pr[p].act = ($urandom_range(0, 2) == 0);
          if (pr[p].act) begin
            pr[p].wr   = 1'($urandom_range(0, 1));
            pr[p].addr = 20'($urandom);
            pr[p].wd   = 16'($urandom);
          end
        end
      end
    end
    reset = 1'b1;
    idle(6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/gpu_ram_arbiter.md
# gpu_ram_arbiter

Three-requester arbiter that shares the single GPU RAM access port between the Z80 bus (port A), the RS232 debugger (port B) and the geometry unit (port C). A and B alternate round-robin. C gets spare cycles, and a starvation watchdog forces a C grant after a bounded wait. The block drives the registered RAM request bus. It tracks in-flight reads in a tag pipeline so each read-ready pulse goes to the requester that issued the read.

## Interface
Parameters:
- READ_CLOCK_CYCLES, 2: RAM read latency, from registered request to valid ram_data_in; legal 1..8.
- GEO_MAX_WAIT, 8: cycles C may wait with c_req high before a forced grant; legal 1..255.
- GEO_ENDIAN_SWAP, 1: 1 swaps bytes of C write data and of C-bound read data.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- a_req, b_req, c_req  in  1 each  request; held with stable fields until the matching ack.
- a_wr, b_wr, c_wr  in  1 each  1 = write, 0 = read.
- a_addr, b_addr, c_addr  in  20 each  byte address.
- a_wdata, b_wdata  in  8 each  write data.
- c_wdata  in  16  write data.
- a_ack, b_ack, c_ack  out  1 each  combinational one-cycle grant pulse.
- ram_rd_req  out  1  registered read strobe.
- ram_wr_ena  out  1  registered write strobe.
- ram_ena_16bit  out  1  1 for C accesses.
- ram_address  out  20  registered address.
- ram_data_out  out  16  registered write data.
- ram_data_in  in  16  RAM read data.
- a_rd_rdy, b_rd_rdy, c_rd_rdy  out  1 each  one-cycle pulse; rd_data valid for that requester.
- rd_data  out  16  read data; A/B use [7:0].
- geo_forced  out  1  registered pulse, one cycle after a watchdog-forced C grant.

## Operation
- At most one ack per cycle. Each cycle the grant is computed combinationally from the *_req inputs and internal state.
- Grant rule, evaluated in order:
  1. If c_req and wait_cnt == GEO_MAX_WAIT, grant C (forced).
  2. Else if a_req and b_req both high, grant the one not granted last; last_ab resets to B, so A wins the first tie.
  3. Else grant whichever of a_req or b_req is high.
  4. Else, if c_req, grant C.
- last_ab updates only on A or B grants; C grants leave it unchanged.
- wait_cnt is 8 bits:
  - clears on c_ack or when c_req is low;
  - otherwise increments, saturating at GEO_MAX_WAIT.
- Forced-grant state (FORCE) lasts exactly the cycle of the forced ack; the next cycle is NORMAL.
- Register stage (cycle after ack):
  - ram_address is the granted address.
  - ram_wr_ena = granted wr; ram_rd_req = granted !wr.
  - ram_ena_16bit = (grant is C).
  - ram_data_out = {8'h00, wdata} for A/B. For C it is c_wdata, byte-swapped when GEO_ENDIAN_SWAP=1.
  - Cycles with no grant drive strobes to 0 and hold address/data.
- Read tag pipeline:
  - 2-bit tag (0 none, 1 A, 2 B, 3 C) enters at the register stage; only reads enter a tag.
  - The tag shifts READ_CLOCK_CYCLES stages and decodes to x_rd_rdy.
- rd_data:
  - equals ram_data_in, combinational;
  - byte-swapped only when the emerging tag is C and GEO_ENDIAN_SWAP=1.
- Writes produce no rd_rdy.

## Timing
- Reset (reset == 0 at a clk edge):
  - all registered outputs become 0: ram strobes, address, data, geo_forced, rd_rdy;
  - wait_cnt = 0, last_ab = B, tag pipeline cleared;
  - acks are 0 while reset is low;
  - reads in flight at reset never produce rd_rdy.
- Ack-to-RAM latency is 1 cycle: an ack at cycle n gives ram_* strobes at n+1.
- Read-ready latency: an ack at cycle n gives x_rd_rdy at n+1+READ_CLOCK_CYCLES.
- Throughput: one access per cycle; back-to-back acks to any mix of ports are legal.
- A requester holding req after its ack is treated as a new request the following cycle.
- Simultaneous requests: when A, B and C all request, A/B alternate every cycle. C is granted only when wait_cnt saturates, so with GEO_MAX_WAIT = W it waits W cycles and is acked on the (W+1)th cycle of continuous request.
- Read return order always matches issue order; no reordering.

## Test plan
- Reset: drive reset = 0 for 3 cycles with all reqs high → no acks, all outputs 0. On release, A is acked first.
- A read at 0x12345 alone, ram_data_in = 0xBEEF at the return cycle → a_ack at cycle n, ram_rd_req with ram_address = 0x12345 at n+1, a_rd_rdy with rd_data[7:0] = 0xEF at n+3.
- A and B both request continuously for 6 cycles → grants A, B, A, B, A, B; no C grant.
- GEO_MAX_WAIT = 4: A/B saturate while c_req is high from cycle 0 → c_ack at cycle 4, geo_forced at cycle 5, then A/B alternation resumes.
- C write 0x1234 to 0x00100 with GEO_ENDIAN_SWAP = 1 → ram_wr_ena, ram_ena_16bit = 1, ram_data_out = 0x3412. A C read returning 0xAABB → c_rd_rdy with rd_data = 0xBBAA.
- Mid-flight reset: issue B read, pull reset low at ack+1 → b_rd_rdy never asserts. After release, a new B read completes normally.
